node_sequencer: RTL and testbench

//  Per-sub_node annealing controller. It issues the per-iteration sequence that drives a sub_node:
//  opt_run -> delta-distance wait -> metropolis exp window -> (periodic) replica exchange.
//  It also grants the host exclusive use of the total-distance and ordering shift chains while idle.
//  One instance sits beside each sub_node (or is shared by all nodes, since they run in lockstep).

---
 rtl/node_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_node_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_sequencer.sv
// Per-sub_node annealing controller: sequences opt_run / delta wait / metropolis exp window /
// periodic replica exchange, and grants the host the distance and ordering shift chains while idle.
module node_sequencer #(
  parameter int DELTA_LAT   = 4,
  parameter int EXP_CYCLES  = 16,
  parameter int EX_INTERVAL = 8,
  parameter int EX_LAT      = 6,
  parameter int SHIFT_LEN   = 32,
  parameter int ITER_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ITER_W-1:0] iter_num,
  input  logic [16:0]       recip_cfg,
  input  logic              host_dis_req,
  input  logic              host_ord_req,
  output logic              host_dis_ack,
  output logic              host_ord_ack,
  output logic              opt_run,
  output logic              exp_init,
  output logic              exp_run,
  output logic              exp_fin,
  output logic [16:0]       exp_recip,
  output logic              ex_run,
  output logic              distance_shift,
  output logic              exchange_shift_d,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {IDLE, HDIS, HORD, OPT, DELTA, EXP, EXCH, DONE} state_t;

  localparam int MAX_A   = (SHIFT_LEN > DELTA_LAT) ? SHIFT_LEN : DELTA_LAT;
  localparam int MAX_B   = (EXP_CYCLES + 2 > EX_LAT + 1) ? EXP_CYCLES + 2 : EX_LAT + 1;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WRAP_W  = (EX_INTERVAL > 1) ? $clog2(EX_INTERVAL) : 1;

  localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0]  DELTA_LAST = CNT_W'(DELTA_LAT - 1);
  localparam logic [CNT_W-1:0]  EXP_LAST   = CNT_W'(EXP_CYCLES + 1);
  localparam logic [CNT_W-1:0]  EXCH_LAST  = CNT_W'(EX_LAT);
  localparam logic [WRAP_W-1:0] WRAP_LAST  = WRAP_W'(EX_INTERVAL - 1);

  state_t              state_q, state_nx;
  logic [CNT_W-1:0]    cnt_q, cnt_nx;
  logic [WRAP_W-1:0]   wrap_q, wrap_nx;
  logic [ITER_W-1:0]   iter_nx;
  logic [ITER_W-1:0]   iter_num_q;
  logic                stop_q, stop_nx;
  logic                stop_hit;
  logic                load;

  logic opt_run_d, exp_init_d, exp_run_d, exp_fin_d, ex_run_d;
  logic dshift_d, oshift_d, dack_d, oack_d, busy_d, done_d;

  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (&v) ? v : v + ITER_W'(1);
  endfunction

  // state register and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wrap_q    <= '0;
      stop_q    <= 1'b0;
      iter_cnt  <= '0;
      exp_recip <= '0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      wrap_q   <= wrap_nx;
      stop_q   <= stop_nx;
      iter_cnt <= iter_nx;
      if (load) exp_recip <= recip_cfg;
    end
  end

  // iteration target is only consulted after a start has loaded it
  always_ff @(posedge clk) begin
    if (load) iter_num_q <= iter_num;
  end

  // next-state logic
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + CNT_W'(1);
    wrap_nx  = wrap_q;
    iter_nx  = iter_cnt;
    stop_nx  = stop_q;
    load     = 1'b0;
    stop_hit = stop_q | stop;
    case (state_q)
      IDLE: begin
        cnt_nx  = '0;
        stop_nx = 1'b0;
        if (host_dis_req) begin
          state_nx = HDIS;
        end else if (host_ord_req) begin
          state_nx = HORD;
        end else if (start) begin
          load     = 1'b1;
          iter_nx  = '0;
          wrap_nx  = '0;
          state_nx = (iter_num == '0) ? DONE : OPT;
        end
      end
      HDIS, HORD: begin
        if (cnt_q == SHIFT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      OPT: begin
        if (stop) stop_nx = 1'b1;
        cnt_nx   = '0;
        state_nx = (DELTA_LAT > 0) ? DELTA : EXP;
      end
      DELTA: begin
        if (stop) stop_nx = 1'b1;
        if (cnt_q == DELTA_LAST) begin
          state_nx = EXP;
          cnt_nx   = '0;
        end
      end
      EXP: begin
        if (stop) stop_nx = 1'b1;
        if (cnt_q == EXP_LAST) begin
          iter_nx = sat_inc(iter_cnt);
          cnt_nx  = '0;
          if (wrap_q == WRAP_LAST) begin
            wrap_nx  = '0;
            state_nx = EXCH;
          end else begin
            wrap_nx  = wrap_q + WRAP_W'(1);
            state_nx = ((iter_nx == iter_num_q) || stop_hit) ? DONE : OPT;
          end
        end
      end
      EXCH: begin
        if (stop) stop_nx = 1'b1;
        if (cnt_q == EXCH_LAST) begin
          cnt_nx   = '0;
          state_nx = ((iter_cnt == iter_num_q) || stop_hit) ? DONE : OPT;
        end
      end
      DONE: begin
        cnt_nx   = '0;
        stop_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // output decode of the upcoming state, registered below
  always_comb begin
    opt_run_d  = (state_nx == OPT);
    exp_init_d = (state_nx == EXP) && (cnt_nx == '0);
    exp_run_d  = (state_nx == EXP) && (cnt_nx != '0) && (cnt_nx != EXP_LAST);
    exp_fin_d  = (state_nx == EXP) && (cnt_nx == EXP_LAST);
    ex_run_d   = (state_nx == EXCH) && (cnt_nx == '0);
    dshift_d   = (state_nx == HDIS);
    oshift_d   = (state_nx == HORD);
    dack_d     = (state_nx == HDIS) && (cnt_nx == SHIFT_LAST);
    oack_d     = (state_nx == HORD) && (cnt_nx == SHIFT_LAST);
    busy_d     = (state_nx != IDLE);
    done_d     = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opt_run          <= 1'b0;
      exp_init         <= 1'b0;
      exp_run          <= 1'b0;
      exp_fin          <= 1'b0;
      ex_run           <= 1'b0;
      distance_shift   <= 1'b0;
      exchange_shift_d <= 1'b0;
      host_dis_ack     <= 1'b0;
      host_ord_ack     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      opt_run          <= opt_run_d;
      exp_init         <= exp_init_d;
      exp_run          <= exp_run_d;
      exp_fin          <= exp_fin_d;
      ex_run           <= ex_run_d;
      distance_shift   <= dshift_d;
      exchange_shift_d <= oshift_d;
      host_dis_ack     <= dack_d;
      host_ord_ack     <= oack_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

endmodule

// File: tb/tb_node_sequencer.sv
// Self-checking bench for node_sequencer: vector table, hand-written corner sequences and
// randomized traffic compared cycle by cycle against an expected-output schedule model.
module tb_node_sequencer;
  localparam int DELTA_LAT   = 4;
  localparam int EXP_CYCLES  = 16;
  localparam int EX_INTERVAL = 8;
  localparam int EX_LAT      = 6;
  localparam int SHIFT_LEN   = 32;
  localparam int ITER_W      = 32;

  localparam logic [10:0] M_OPT  = 11'h001;
  localparam logic [10:0] M_INIT = 11'h002;
  localparam logic [10:0] M_RUN  = 11'h004;
  localparam logic [10:0] M_FIN  = 11'h008;
  localparam logic [10:0] M_EX   = 11'h010;
  localparam logic [10:0] M_DSH  = 11'h020;
  localparam logic [10:0] M_OSH  = 11'h040;
  localparam logic [10:0] M_DACK = 11'h080;
  localparam logic [10:0] M_OACK = 11'h100;
  localparam logic [10:0] M_BUSY = 11'h200;
  localparam logic [10:0] M_DONE = 11'h400;

  logic              clk = 1'b0;
  logic              reset, start, stop, host_dis_req, host_ord_req;
  logic [ITER_W-1:0] iter_num;
  logic [16:0]       recip_cfg;
  logic              host_dis_ack, host_ord_ack, opt_run, exp_init, exp_run, exp_fin, ex_run;
  logic              distance_shift, exchange_shift_d, busy, done;
  logic [16:0]       exp_recip;
  logic [ITER_W-1:0] iter_cnt;

  int total = 0;
  int bad   = 0;

  node_sequencer #(
    .DELTA_LAT(DELTA_LAT), .EXP_CYCLES(EXP_CYCLES), .EX_INTERVAL(EX_INTERVAL),
    .EX_LAT(EX_LAT), .SHIFT_LEN(SHIFT_LEN), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .iter_num(iter_num),
    .recip_cfg(recip_cfg), .host_dis_req(host_dis_req), .host_ord_req(host_ord_req),
    .host_dis_ack(host_dis_ack), .host_ord_ack(host_ord_ack), .opt_run(opt_run),
    .exp_init(exp_init), .exp_run(exp_run), .exp_fin(exp_fin), .exp_recip(exp_recip),
    .ex_run(ex_run), .distance_shift(distance_shift), .exchange_shift_d(exchange_shift_d),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {done, busy, host_ord_ack, host_dis_ack, exchange_shift_d, distance_shift,
            ex_run, exp_fin, exp_run, exp_init, opt_run};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Expected behaviour as a schedule of per-cycle output words
  typedef struct {
    logic [10:0] bits;
    int          cnt;
    int          itn;
    bit          iter_end;
  } word_t;

  word_t       mq[$];
  int          m_last_cnt = 0;
  logic [16:0] m_recip = '0;

  function automatic void push(input logic [10:0] bits, input int cnt, input int itn, input bit e);
    word_t w;
    w.bits = bits | M_BUSY;
    w.cnt = cnt;
    w.itn = itn;
    w.iter_end = e;
    mq.push_back(w);
  endfunction

  function automatic void push_run(input int n);
    for (int k = 1; k <= n; k++) begin
      bit exch;
      exch = (k % EX_INTERVAL) == 0;
      push(M_OPT, k - 1, k, 1'b0);
      for (int i = 0; i < DELTA_LAT; i++) push('0, k - 1, k, 1'b0);
      push(M_INIT, k - 1, k, 1'b0);
      for (int i = 0; i < EXP_CYCLES; i++) push(M_RUN, k - 1, k, 1'b0);
      push(M_FIN, k - 1, k, !exch);
      if (exch) begin
        push(M_EX, k, k, EX_LAT == 0);
        for (int i = 0; i < EX_LAT; i++) push('0, k, k, i == EX_LAT - 1);
      end
    end
    push(M_DONE, n, 0, 1'b0);
  endfunction

  function automatic void push_shift(input bit dis);
    for (int i = 0; i < SHIFT_LEN; i++) begin
      if (dis) push(M_DSH | ((i == SHIFT_LEN - 1) ? M_DACK : 11'h0), m_last_cnt, 0, 1'b0);
      else     push(M_OSH | ((i == SHIFT_LEN - 1) ? M_OACK : 11'h0), m_last_cnt, 0, 1'b0);
    end
  endfunction

  logic [10:0] mon_exp;
  int          mon_cnt, mon_idx, mon_k;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_last_cnt = 0;
      m_recip = '0;
      chk("reset_outputs", 64'(outs()), 64'h0);
      chk("reset_iter_cnt", 64'(iter_cnt), 64'h0);
      chk("reset_recip", 64'(exp_recip), 64'h0);
    end else begin
      if (mq.size() > 0) begin
        mon_exp = mq[0].bits;
        mon_cnt = mq[0].cnt;
      end else begin
        mon_exp = '0;
        mon_cnt = m_last_cnt;
      end
      chk("model_outputs", 64'(outs()), 64'(mon_exp));
      chk("model_iter_cnt", 64'(iter_cnt), 64'(mon_cnt));
      chk("model_recip", 64'(exp_recip), 64'(m_recip));
      if (mq.size() == 0) begin
        if (host_dis_req) push_shift(1'b1);
        else if (host_ord_req) push_shift(1'b0);
        else if (start) begin
          m_recip = recip_cfg;
          if (iter_num == '0) push(M_DONE, 0, 0, 1'b0);
          else push_run(int'(iter_num));
        end
      end else begin
        if (stop && mq[0].itn != 0) begin
          mon_idx = 0;
          while (!mq[mon_idx].iter_end) mon_idx++;
          mon_k = mq[mon_idx].itn;
          while (mq.size() > mon_idx + 1) void'(mq.pop_back());
          push(M_DONE, mon_k, 0, 1'b0);
        end
        m_last_cnt = mq[0].cnt;
        void'(mq.pop_front());
      end
    end
  end

  typedef struct {
    int          n;
    logic [16:0] recip;
    int          done_at;
    int          ex;
    int          cnt;
  } vec_t;

  vec_t tbl[6];
  int t_n, t_ex, opt_at, init_at, run_first, run_cnt, fin_at, done_at, cnt_at_done;
  int ds_cnt, dack_at, os_cnt, oack_at, ds2_at, t_done;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1,  17'h1abcd, 24,  0, 1};
    tbl[1] = '{0,  17'h00011, 1,   0, 0};
    tbl[2] = '{3,  17'h0beef, 70,  0, 3};
    tbl[3] = '{8,  17'h12345, 192, 1, 8};
    tbl[4] = '{9,  17'h00f00, 215, 1, 9};
    tbl[5] = '{16, 17'h1ffff, 383, 2, 16};

    reset = 1'b0; start = 1'b1; stop = 1'b0; host_dis_req = 1'b0; host_ord_req = 1'b0;
    iter_num = '0; recip_cfg = 17'h15555;

    // reset held with start asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_outputs", 64'(outs()), 64'h0);
    chk("rst_hold_busy", 64'(busy), 64'h0);
    chk("rst_hold_iter_cnt", 64'(iter_cnt), 64'h0);
    start = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("post_reset_idle", 64'(outs()), 64'h0);

    // vector table: run length, exchange count, final count, latched recip
    for (int i = 0; i < 6; i++) begin
      iter_num = ITER_W'(tbl[i].n);
      recip_cfg = tbl[i].recip;
      start = 1'b1;
      t_ex = 0;
      @(posedge clk); #1;
      start = 1'b0;
      t_n = 1;
      while (done !== 1'b1 && t_n < 1000) begin
        if (ex_run) t_ex++;
        @(posedge clk); #1;
        t_n++;
      end
      chk("vec_done_at", 64'(t_n), 64'(tbl[i].done_at));
      chk("vec_ex_runs", 64'(t_ex), 64'(tbl[i].ex));
      chk("vec_iter_cnt", 64'(iter_cnt), 64'(tbl[i].cnt));
      chk("vec_recip", 64'(exp_recip), 64'(tbl[i].recip));
      @(posedge clk); #1;
    end

    // single iteration timeline
    iter_num = 1; recip_cfg = 17'h00777; start = 1'b1;
    opt_at = -1; init_at = -1; run_first = -1; run_cnt = 0; fin_at = -1; done_at = -1; t_ex = 0;
    cnt_at_done = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (opt_run && opt_at < 0) opt_at = n;
      if (exp_init && init_at < 0) init_at = n;
      if (exp_run) begin
        run_cnt++;
        if (run_first < 0) run_first = n;
      end
      if (exp_fin && fin_at < 0) fin_at = n;
      if (ex_run) t_ex++;
      if (done && done_at < 0) begin
        done_at = n;
        cnt_at_done = int'(iter_cnt);
      end
    end
    chk("one_opt_at", 64'(opt_at), 64'd1);
    chk("one_init_at", 64'(init_at), 64'd6);
    chk("one_run_first", 64'(run_first), 64'd7);
    chk("one_run_cnt", 64'(run_cnt), 64'd16);
    chk("one_fin_at", 64'(fin_at), 64'd23);
    chk("one_done_at", 64'(done_at), 64'd24);
    chk("one_no_ex", 64'(t_ex), 64'd0);
    chk("one_iter_cnt", 64'(cnt_at_done), 64'd1);

    // stop during DELTA of iteration 3
    iter_num = 100; start = 1'b1; done_at = -1; cnt_at_done = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop = (n == 49);
      if (done && done_at < 0) begin
        done_at = n;
        cnt_at_done = int'(iter_cnt);
      end
    end
    stop = 1'b0;
    chk("stop_done_at", 64'(done_at), 64'd70);
    chk("stop_iter_cnt", 64'(cnt_at_done), 64'd3);
    chk("stop_idle", 64'(busy), 64'd0);

    // host requests arbitrated against start, then a request during a run
    iter_num = 2; start = 1'b1; host_dis_req = 1'b1; host_ord_req = 1'b1;
    ds_cnt = 0; dack_at = -1; os_cnt = 0; oack_at = -1; opt_at = -1; done_at = -1; ds2_at = -1;
    for (int n = 1; n <= 160; n++) begin
      @(posedge clk); #1;
      if (n == 1) host_dis_req = 1'b0;
      if (n == 80) host_dis_req = 1'b1;
      if (distance_shift) begin
        if (n < 100) ds_cnt++;
        else if (ds2_at < 0) ds2_at = n;
      end
      if (host_dis_ack && n < 100 && dack_at < 0) dack_at = n;
      if (host_dis_ack && n >= 100) host_dis_req = 1'b0;
      if (exchange_shift_d) os_cnt++;
      if (host_ord_ack && oack_at < 0) begin
        oack_at = n;
        host_ord_req = 1'b0;
      end
      if (opt_run && opt_at < 0) begin
        opt_at = n;
        start = 1'b0;
      end
      if (done && done_at < 0) done_at = n;
    end
    host_dis_req = 1'b0; host_ord_req = 1'b0; start = 1'b0;
    chk("host_dshift_len", 64'(ds_cnt), 64'd32);
    chk("host_dack_at", 64'(dack_at), 64'd32);
    chk("host_oshift_len", 64'(os_cnt), 64'd32);
    chk("host_oack_at", 64'(oack_at), 64'd65);
    chk("host_run_opt_at", 64'(opt_at), 64'd67);
    chk("host_run_done_at", 64'(done_at), 64'd113);
    chk("host_deferred_dshift_at", 64'(ds2_at), 64'd115);

    // zero-iteration start, then async reset in the middle of EXP
    iter_num = 0; start = 1'b1; opt_at = -1; done_at = -1;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (opt_run) opt_at = n;
      if (done && done_at < 0) done_at = n;
    end
    chk("zero_done_at", 64'(done_at), 64'd1);
    chk("zero_no_opt", 64'(opt_at), 64'hffff_ffff_ffff_ffff);

    iter_num = 5; recip_cfg = 17'h0f0f0; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_reset_exp_run", 64'(exp_run), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(outs()), 64'h0);
    chk("async_reset_iter_cnt", 64'(iter_cnt), 64'h0);
    chk("async_reset_recip", 64'(exp_recip), 64'h0);
    t_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) t_done++;
    end
    reset = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) t_done++;
    end
    chk("async_reset_no_done", 64'(t_done), 64'd0);
    chk("async_reset_idle", 64'(busy), 64'd0);

    // randomized traffic checked by the schedule model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (reset == 1'b0) reset = 1'b1;
      else if ($urandom_range(0, 1499) == 0) reset = 1'b0;
      start = ($urandom_range(0, 9) == 0);
      iter_num = ITER_W'($urandom_range(0, 10));
      recip_cfg = 17'($urandom);
      stop = ($urandom_range(0, 59) == 0);
      host_dis_req = ($urandom_range(0, 39) == 0);
      host_ord_req = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; stop = 1'b0; host_dis_req = 1'b0; host_ord_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
